// File: rtl/uart_pkg.sv
// Shared types and constants for the round-robin UART transmit scheduler.
package uart_pkg;

    typedef enum logic [2:0] {
        UART_IDLE   = 3'd0,
        UART_ARMED  = 3'd1,
        UART_START  = 3'd2,
        UART_DATA   = 3'd3,
        UART_PARITY = 3'd4,
        UART_STOP   = 3'd5
    } uart_state_e;

    localparam int UART_DATA_W          = 8;
    localparam int UART_FRAME_LEN_PAR   = 11;
    localparam int UART_FRAME_LEN_NOPAR = 10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first valid index at or after rr_ptr,
// searching upward with wrap-around.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic             gnt_valid,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx
);

    int j;

    // Scan from the farthest offset down so the nearest valid index wins.
    always_comb begin
        gnt_valid  = 1'b0;
        gnt_onehot = '0;
        gnt_idx    = '0;
        j          = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(rr_ptr) + k) % N_REQ;
            if (req_valid[j]) begin
                gnt_valid     = 1'b1;
                gnt_onehot    = '0;
                gnt_onehot[j] = 1'b1;
                gnt_idx       = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART TX line among N_REQ byte requesters with round-robin grant.
// Define UART_TX_PARITY_EN to insert an even parity bit (11-bit frame).
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int DATA_W = 8,
    localparam int IDX_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    intx,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx,
    output logic                    busy,
    output logic [IDX_W-1:0]        grant_id,
    output logic                    frame_done
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_W - 1);

    uart_state_e        state_q, state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic [N_REQ-1:0]   req_ready_q, req_ready_d;
    logic [IDX_W-1:0]   grant_id_q, grant_id_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic               gnt_valid;
    logic [N_REQ-1:0]   gnt_onehot;
    logic [IDX_W-1:0]   gnt_idx;
    logic [DATA_W-1:0]  req_bytes [N_REQ];
    logic [DATA_W-1:0]  gnt_byte;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_valid  (req_valid),
        .rr_ptr     (rr_ptr_q),
        .gnt_valid  (gnt_valid),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
        assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
    end

    always_comb begin
        gnt_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_onehot[i]) gnt_byte = gnt_byte | req_bytes[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        tx_d         = tx_q;
        frame_done_d = 1'b0;
        req_ready_d  = '0;
        grant_id_d   = grant_id_q;
        rr_ptr_d     = rr_ptr_q;

        case (state_q)
            UART_IDLE: begin
                // Acceptance ignores intx; the start bit waits for a later tick.
                if (gnt_valid) begin
                    req_ready_d = gnt_onehot;
                    shreg_d     = gnt_byte;
                    grant_id_d  = gnt_idx;
                    rr_ptr_d    = (gnt_idx == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
                    state_d     = UART_ARMED;
                end
            end
            UART_ARMED: begin
                if (intx) begin
                    tx_d    = 1'b0;
                    state_d = UART_START;
                end
            end
            UART_START: begin
                if (intx) begin
                    tx_d      = shreg_q[0];
                    bit_cnt_d = '0;
                    state_d   = UART_DATA;
                end
            end
            UART_DATA: begin
                if (intx) begin
                    if (bit_cnt_q != LAST_BIT) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shreg_q[bit_cnt_q + 3'd1];
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = ^shreg_q;
                        state_d = UART_PARITY;
`else
                        tx_d    = 1'b1;
                        state_d = UART_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            UART_PARITY: begin
                if (intx) begin
                    tx_d    = 1'b1;
                    state_d = UART_STOP;
                end
            end
`endif
            UART_STOP: begin
                if (intx) begin
                    frame_done_d = 1'b1;
                    state_d      = UART_IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = UART_IDLE;
            end
        endcase

        busy_d = (state_d != UART_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= UART_IDLE;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            req_ready_q  <= '0;
            grant_id_q   <= '0;
            rr_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            req_ready_q  <= req_ready_d;
            grant_id_q   <= grant_id_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign grant_id   = grant_id_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (N_REQ=4); expectations
// follow UART_TX_PARITY_EN when it is defined for the build.
module tb_uart_tx_scheduler;

    localparam int N_REQ = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        intx;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx;
    logic        busy;
    logic [1:0]  grant_id;
    logic        frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_scheduler #(.N_REQ(N_REQ), .DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .intx       (intx),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .tx         (tx),
        .busy       (busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    always #3 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected line level after the (i+1)-th tick of a frame.
    function automatic logic exp_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return d[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic tick();
        repeat (2) @(negedge clk);
        intx = 1'b1;
        @(negedge clk);
        intx = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ready(output logic [3:0] rv);
        rv = '0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0) begin
                rv = req_ready;
                break;
            end
        end
        check_eq("ready_seen", 32'(rv != 4'b0), 32'd1);
    endtask

    task automatic request(input int idx, input logic [7:0] d);
        logic [3:0] rv;
        req_data[idx*8 +: 8] = d;
        req_valid[idx]       = 1'b1;
        wait_ready(rv);
        req_valid[idx]       = 1'b0;
        check_eq("req_ready", 32'(rv), 32'(4'b1 << idx));
        check_eq("grant_id", 32'(grant_id), 32'(idx));
        check_eq("busy_armed", 32'(busy), 32'd1);
        $display("grant req %0d data 0x%02h", idx, d);
    endtask

    // Ticks through one frame; pulse_at >= 0 flashes req_valid[3] before that tick.
    task automatic run_frame(input logic [7:0] d, input int pulse_at);
        for (int i = 0; i < FL; i++) begin
            if (i == pulse_at) begin
                @(negedge clk);
                req_valid[3] = 1'b1;
                @(negedge clk);
                req_valid[3] = 1'b0;
            end
            tick();
            check_eq($sformatf("tx_bit%0d", i), 32'(tx), 32'(exp_bit(d, i)));
            check_eq("frame_done_early", 32'(frame_done), 32'd0);
            check_eq("ready_in_frame", 32'(req_ready), 32'd0);
        end
        tick();
        check_eq("frame_done", 32'(frame_done), 32'd1);
        check_eq("tx_after_stop", 32'(tx), 32'd1);
        check_eq("busy_after_stop", 32'(busy), 32'd0);
        $display("frame data 0x%02h sent, %0d bits", d, FL);
    endtask

    initial begin
        logic [3:0] rv;
        logic [7:0] held_bytes [4];
        held_bytes[0] = 8'h11; held_bytes[1] = 8'h82;
        held_bytes[2] = 8'h3C; held_bytes[3] = 8'hE7;

        reset = 1'b1; intx = 1'b0; req_valid = '0; req_data = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", 32'(tx), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        check_eq("rst_grant_id", 32'(grant_id), 32'd0);
        reset = 1'b0;

        // Idle ticks with no request leave the line high.
        tick();
        check_eq("idle_tx", 32'(tx), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);

        request(2, 8'hA5);
        run_frame(8'hA5, -1);
        check_eq("grant_id_after", 32'(grant_id), 32'd2);

        request(0, 8'h0F);
        run_frame(8'h0F, -1);
        request(0, 8'h00);
        run_frame(8'h00, -1);

        // Short pulse on req 3 while busy must be ignored.
        request(1, 8'h96);
        run_frame(8'h96, 4);
        repeat (3) begin
            @(negedge clk);
            check_eq("no_grant_3", 32'(req_ready), 32'd0);
            check_eq("idle_busy_2", 32'(busy), 32'd0);
        end

        // All four held from reset: strict rotation 0,1,2,3,0.
        do_reset();
        req_data  = {held_bytes[3], held_bytes[2], held_bytes[1], held_bytes[0]};
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            wait_ready(rv);
            if (k == 4) req_valid = '0;
            check_eq("rr_grant", 32'(rv), 32'(4'b1 << (k % 4)));
            check_eq("rr_onehot", 32'($countones(rv)), 32'd1);
            check_eq("rr_grant_id", 32'(grant_id), 32'(k % 4));
            $display("rr grant %0d", k % 4);
            run_frame(held_bytes[k % 4], -1);
        end

        // Reset during DATA bit 4 aborts the frame and clears rr_ptr.
        do_reset();
        request(2, 8'h5A);
        for (int i = 0; i < 6; i++) tick();
        check_eq("pre_rst_tx", 32'(tx), 32'(exp_bit(8'h5A, 5)));
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("midrst_tx", 32'(tx), 32'd1);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_grant_id", 32'(grant_id), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        req_data[15:8]  = 8'h6B;
        req_data[31:24] = 8'hD4;
        req_valid = 4'b1010;
        wait_ready(rv);
        req_valid = '0;
        check_eq("post_rst_grant", 32'(rv), 32'b0010);
        run_frame(8'h6B, -1);

        // Tick coinciding with the accept cycle does not start the frame.
        @(negedge clk);
        req_data[7:0] = 8'hC3;
        req_valid[0]  = 1'b1;
        intx          = 1'b1;
        @(negedge clk);
        intx          = 1'b0;
        req_valid[0]  = 1'b0;
        check_eq("acc_tick_ready", 32'(req_ready), 32'b0001);
        check_eq("acc_tick_tx", 32'(tx), 32'd1);
        check_eq("acc_tick_busy", 32'(busy), 32'd1);
        run_frame(8'hC3, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
